// File: rtl/lfsr4_checker.sv
// Self-synchronising checker for the 4-bit LFSR pattern stream.
// Optional match statistics counter: define LFSR_CHK_STATS_EN.
module lfsr4_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       data_in,
    input  logic             poly_sel,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      match_cnt
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       predict_q, predict_d;
    logic [3:0]       hit_q, hit_d;
    logic [3:0]       miss_q, miss_d;
    logic             poly_q;
    logic             pulse_q, pulse_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       hit_inc;
    logic [3:0]       miss_inc;
    logic             poly_chg;

    function automatic logic [3:0] nxt(input logic [3:0] s, input logic p);
        return {s[2:0], p ? (s[3] ^ s[0]) : (s[3] ^ s[2])};
    endfunction

    assign hit_inc  = hit_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;
    assign poly_chg = poly_sel != poly_q;

    always_comb begin
        state_d   = state_q;
        predict_d = predict_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        pulse_d   = 1'b0;
        err_d     = err_q;
        if (poly_chg) begin
            // a polynomial switch invalidates the running prediction
            state_d   = HUNT;
            predict_d = 4'd0;
            hit_d     = 4'd0;
            miss_d    = 4'd0;
        end else if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (data_in != 4'd0) begin
                        predict_d = nxt(data_in, poly_q);
                        hit_d     = 4'd0;
                        state_d   = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_in == predict_q) begin
                        hit_d     = hit_inc;
                        predict_d = nxt(data_in, poly_q);
                        if (hit_inc == 4'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (data_in != 4'd0) begin
                        predict_d = nxt(data_in, poly_q);
                        hit_d     = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    predict_d = nxt(predict_q, poly_q);
                    if (data_in == predict_q) begin
                        miss_d = 4'd0;
                    end else begin
                        pulse_d = 1'b1;
                        miss_d  = miss_inc;
                        if (err_q != {ERR_W{1'b1}})
                            err_d = err_q + ERR_W'(1);
                        if (miss_inc == 4'(LOSS_CNT))
                            state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (err_clr)
            err_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            predict_q <= 4'd0;
            hit_q     <= 4'd0;
            miss_q    <= 4'd0;
            poly_q    <= 1'b0;
            pulse_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            predict_q <= predict_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            poly_q    <= poly_sel;
            pulse_q   <= pulse_d;
            err_q     <= err_d;
        end
    end

    assign locked    = state_q == LOCKED;
    assign err_pulse = pulse_q;
    assign err_cnt   = err_q;

`ifdef LFSR_CHK_STATS_EN
    logic [15:0] match_q;
    logic        match_inc;

    assign match_inc = in_valid && !poly_chg && (state_q == LOCKED)
                       && (data_in == predict_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            match_q <= 16'd0;
        else if (err_clr)
            match_q <= 16'd0;
        else if (match_inc)
            match_q <= match_q + 16'd1;
    end

    assign match_cnt = match_q;
`else
    assign match_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr4_checker.sv
// Directed-vector bench for lfsr4_checker.
module tb_lfsr4_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  data_in = 4'd0;
    logic        poly_sel = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic [15:0] match_cnt;

    int tests = 0;
    int fails = 0;

    lfsr4_checker dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .data_in  (data_in),
        .poly_sel (poly_sel),
        .err_clr  (err_clr),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  d;
        logic        p;
        logic        c;
        logic        l;
        logic        pu;
        logic [7:0]  e;
        logic [15:0] m;
    } vec_t;

    vec_t tbl[23];

    function automatic logic [3:0] stim_next(input logic [3:0] s, input logic p);
        return {s[2:0], p ? (s[3] ^ s[0]) : (s[3] ^ s[2])};
    endfunction

    function automatic logic [15:0] mexp(input logic [15:0] m);
`ifdef LFSR_CHK_STATS_EN
        return m;
`else
        return 16'h0000 & m;
`endif
    endfunction

    task automatic check(input string nm, input int idx, input logic l,
                         input logic pu, input logic [7:0] e,
                         input logic [15:0] m);
        tests++;
        if (locked !== l) begin
            fails++;
            $display("FAIL %s[%0d] locked got %b want %b", nm, idx, locked, l);
        end
        tests++;
        if (err_pulse !== pu) begin
            fails++;
            $display("FAIL %s[%0d] err_pulse got %b want %b", nm, idx, err_pulse, pu);
        end
        tests++;
        if (err_cnt !== e) begin
            fails++;
            $display("FAIL %s[%0d] err_cnt got %0d want %0d", nm, idx, err_cnt, e);
        end
        tests++;
        if (match_cnt !== mexp(m)) begin
            fails++;
            $display("FAIL %s[%0d] match_cnt got %0d want %0d", nm, idx, match_cnt, mexp(m));
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic p,
                         input logic c);
        in_valid = v;
        data_in  = d;
        poly_sel = p;
        err_clr  = c;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] cur;

    initial begin
        //            v   d     p   c   l   pu  e    m
        tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
        tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
        tbl[2]  = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
        tbl[3]  = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
        tbl[4]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0};
        tbl[5]  = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'd1};
        tbl[6]  = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 16'd1};
        tbl[7]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 16'd2};
        tbl[8]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 16'd3};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 16'd3};
        tbl[10] = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 16'd4};
        tbl[11] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 16'd4};
        tbl[12] = '{1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 16'd4};
        tbl[13] = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 16'd4};
        tbl[14] = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 16'd4};
        tbl[15] = '{1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 16'd4};
        tbl[16] = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 16'd4};
        tbl[17] = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 16'd4};
        tbl[18] = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 16'd4};
        tbl[19] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 16'd0};
        tbl[20] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 16'd0};
        tbl[21] = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 16'd1};
        tbl[22] = '{1'b1, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'd1};

        #2;
        check("reset", 0, 1'b0, 1'b0, 8'd0, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        check("idle", 0, 1'b0, 1'b0, 8'd0, 16'd0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].c);
            check("vec", i, tbl[i].l, tbl[i].pu, tbl[i].e, tbl[i].m);
        end

        // zeros never seed the hunt
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'h0, 1'b1, 1'b0);
            check("zeros", i, 1'b0, 1'b0, 8'd1, 16'd1);
        end

        drive(1'b1, 4'h1, 1'b1, 1'b0);
        check("p1seq", 0, 1'b0, 1'b0, 8'd1, 16'd1);
        drive(1'b1, 4'h3, 1'b1, 1'b0);
        check("p1seq", 1, 1'b0, 1'b0, 8'd1, 16'd1);
        drive(1'b1, 4'h7, 1'b1, 1'b0);
        check("p1seq", 2, 1'b0, 1'b0, 8'd1, 16'd1);
        drive(1'b1, 4'hF, 1'b1, 1'b0);
        check("p1seq", 3, 1'b0, 1'b0, 8'd1, 16'd1);
        drive(1'b1, 4'hE, 1'b1, 1'b0);
        check("p1seq", 4, 1'b1, 1'b0, 8'd1, 16'd1);

        drive(1'b0, 4'h0, 1'b1, 1'b1);
        check("clr_idle", 0, 1'b1, 1'b0, 8'd0, 16'd0);

        cur = 4'hD;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, cur, 1'b1, 1'b0);
            cur = stim_next(cur, 1'b1);
        end
        check("match20", 0, 1'b1, 1'b0, 8'd0, 16'd20);

        // alternate wrong/correct so lock holds while err_cnt saturates
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, ~cur, 1'b1, 1'b0);
            cur = stim_next(cur, 1'b1);
            drive(1'b1, cur, 1'b1, 1'b0);
            cur = stim_next(cur, 1'b1);
        end
        check("sat", 0, 1'b1, 1'b0, 8'd255, 16'd280);
        drive(1'b1, ~cur, 1'b1, 1'b0);
        cur = stim_next(cur, 1'b1);
        check("sat", 1, 1'b1, 1'b1, 8'd255, 16'd280);

        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst", 0, 1'b0, 1'b0, 8'd0, 16'd0);
        in_valid = 1'b0;
        poly_sel = 1'b0;
        @(posedge clk);
        #1;
        check("async_rst", 1, 1'b0, 1'b0, 8'd0, 16'd0);
        reset = 1'b0;

        drive(1'b1, 4'h1, 1'b0, 1'b0);
        check("relock", 0, 1'b0, 1'b0, 8'd0, 16'd0);
        drive(1'b1, 4'h2, 1'b0, 1'b0);
        drive(1'b1, 4'h4, 1'b0, 1'b0);
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        check("relock", 1, 1'b0, 1'b0, 8'd0, 16'd0);
        drive(1'b1, 4'h3, 1'b0, 1'b0);
        check("relock", 2, 1'b1, 1'b0, 8'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
